bridge_slave_port_ctrl: RTL and testbench

// - Slave-end counterpart of the bridge master-side response/request block: one instance per bridge slave port.
// - Arbitrates N_MASTER one-hot-ID'd requests round-robin onto a single slave port.
// - Records the ID of each granted request in an in-order FIFO.
// - Routes each slave response back to the originating master as a registered r_valid strobe.
// - Sits between the bridge ARB side (data_req_o/data_ID_o of the master blocks) and one peripheral/L2 port.

---
 rtl/bridge_slave_port_ctrl_pkg.sv | 19 +
 rtl/bridge_slave_port_ctrl_id_fifo.sv | 60 ++++++
 rtl/bridge_slave_port_ctrl.sv | 136 +++++++++++++
 tb/tb_bridge_slave_port_ctrl.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_slave_port_ctrl_pkg.sv
// Shared definitions for the bridge slave-port controller and its ID FIFO.
package bridge_pkg;

  // IDs are one-hot over the masters, so the ID width equals the master count
  function automatic int unsigned id_width(int unsigned n_master);
    return n_master;
  endfunction

  // Counter must represent 0..max_outst inclusive
  function automatic int unsigned outst_cnt_width(int unsigned max_outst);
    return $clog2(max_outst + 1);
  endfunction

  // Pointer width for a circular index over 'depth' entries, never narrower than 1 bit
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bridge_slave_port_ctrl_id_fifo.sv
// In-order FIFO of one-hot master IDs for granted, not yet answered transactions.
module bridge_id_fifo
  import bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned CW   = outst_cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bridge_slave_port_ctrl.sv
// Slave-end bridge port: round-robin arbitration of N_MASTER requests onto one
// slave port, in-order ID tracking, and registered response routing.
module bridge_slave_port_ctrl
  import bridge_pkg::*;
#(
  parameter int unsigned N_MASTER   = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned AUX_WIDTH  = 8,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_MASTER-1:0]                  data_req_i,
  input  logic [N_MASTER-1:0][ADDR_WIDTH-1:0]  data_add_i,
  input  logic [N_MASTER-1:0]                  data_wen_i,
  input  logic [N_MASTER-1:0][DATA_WIDTH-1:0]  data_wdata_i,
  input  logic [N_MASTER-1:0][BE_WIDTH-1:0]    data_be_i,
  input  logic [N_MASTER-1:0][AUX_WIDTH-1:0]   data_aux_i,
  input  logic [N_MASTER-1:0][N_MASTER-1:0]    data_ID_i,
  output logic [N_MASTER-1:0]                  data_gnt_o,
  output logic [N_MASTER-1:0]                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                data_r_rdata_o,
  output logic                                 data_r_opc_o,
  output logic [AUX_WIDTH-1:0]                 data_r_aux_o,
  output logic                                 slv_req_o,
  output logic [ADDR_WIDTH-1:0]                slv_add_o,
  output logic                                 slv_wen_o,
  output logic [DATA_WIDTH-1:0]                slv_wdata_o,
  output logic [BE_WIDTH-1:0]                  slv_be_o,
  output logic [AUX_WIDTH-1:0]                 slv_aux_o,
  input  logic                                 slv_gnt_i,
  input  logic                                 slv_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                slv_r_rdata_i,
  input  logic                                 slv_r_opc_i,
  input  logic [AUX_WIDTH-1:0]                 slv_r_aux_i
);

  localparam int unsigned ID_WIDTH = id_width(N_MASTER);
  localparam int unsigned MW       = ptr_width(N_MASTER);
  localparam int unsigned CW       = outst_cnt_width(MAX_OUTST);

  logic [MW-1:0]       rr_ptr;
  logic [MW-1:0]       winner;
  logic [MW-1:0]       cand;
  logic                hit;
  logic                handshake;
  logic                pop_ok;
  logic [ID_WIDTH-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       outst_cnt;

  // Round-robin search: first requester at or above rr_ptr, wrapping around
  always_comb begin
    winner = rr_ptr;
    cand   = '0;
    hit    = 1'b0;
    for (int unsigned k = 0; k < N_MASTER; k++) begin
      cand = MW'((32'(rr_ptr) + k) % N_MASTER);
      if (!hit && data_req_i[cand]) begin
        winner = cand;
        hit    = 1'b1;
      end
    end
  end

  // Full is taken from the registered count only, so a same-cycle pop cannot re-open the request
  assign slv_req_o   = (|data_req_i) & ~fifo_full;
  assign handshake   = slv_req_o & slv_gnt_i;
  assign pop_ok      = slv_r_valid_i & ~fifo_empty;

  assign slv_add_o   = data_add_i[winner];
  assign slv_wen_o   = data_wen_i[winner];
  assign slv_wdata_o = data_wdata_i[winner];
  assign slv_be_o    = data_be_i[winner];
  assign slv_aux_o   = data_aux_i[winner];

  // Zero-cycle grant back to the winning master on handshake
  always_comb begin
    data_gnt_o = '0;
    if (handshake) data_gnt_o[winner] = 1'b1;
  end

  // Advance the round-robin pointer past the winner only on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rr_ptr <= '0;
    else if (handshake) rr_ptr <= (winner == MW'(N_MASTER - 1)) ? '0 : winner + 1'b1;
  end

  bridge_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (ID_WIDTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (handshake),
    .pop   (pop_ok),
    .din   (data_ID_i[winner]),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outst_cnt)
  );

  // Register the response and steer the valid strobe to the owner's ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r_valid_o <= '0;
      data_r_rdata_o <= '0;
      data_r_opc_o   <= 1'b0;
      data_r_aux_o   <= '0;
    end else begin
      data_r_valid_o <= pop_ok ? fifo_head : '0;
      if (pop_ok) begin
        data_r_rdata_o <= slv_r_rdata_i;
        data_r_opc_o   <= slv_r_opc_i;
        data_r_aux_o   <= slv_r_aux_i;
      end
    end
  end

  a_id_onehot : assert property (@(posedge clk) disable iff (rst)
    handshake |-> $onehot(data_ID_i[winner]))
    else $error("granted request carries a non one-hot ID");

  a_resp_when_empty : assert property (@(posedge clk) disable iff (rst)
    slv_r_valid_i |-> !fifo_empty)
    else $warning("slave response with no outstanding transaction ignored");

  a_cnt_range : assert property (@(posedge clk) disable iff (rst)
    outst_cnt <= CW'(MAX_OUTST))
    else $error("outstanding count out of range");

endmodule

// File: tb/tb_bridge_slave_port_ctrl.sv
// Bench for bridge_slave_port_ctrl: a negedge slave model and scoreboard queue
// of granted IDs, plus per-scenario tasks with their own inline checks.
module tb_bridge_slave_port_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned XW = 8;
  localparam int unsigned MO = 4;

  logic                  clk;
  logic                  rst;
  logic [N-1:0]          data_req_i;
  logic [N-1:0][AW-1:0]  data_add_i;
  logic [N-1:0]          data_wen_i;
  logic [N-1:0][DW-1:0]  data_wdata_i;
  logic [N-1:0][BW-1:0]  data_be_i;
  logic [N-1:0][XW-1:0]  data_aux_i;
  logic [N-1:0][N-1:0]   data_ID_i;
  logic [N-1:0]          data_gnt_o;
  logic [N-1:0]          data_r_valid_o;
  logic [DW-1:0]         data_r_rdata_o;
  logic                  data_r_opc_o;
  logic [XW-1:0]         data_r_aux_o;
  logic                  slv_req_o;
  logic [AW-1:0]         slv_add_o;
  logic                  slv_wen_o;
  logic [DW-1:0]         slv_wdata_o;
  logic [BW-1:0]         slv_be_o;
  logic [XW-1:0]         slv_aux_o;
  logic                  slv_gnt_i;
  logic                  slv_r_valid_i;
  logic [DW-1:0]         slv_r_rdata_i;
  logic                  slv_r_opc_i;
  logic [XW-1:0]         slv_r_aux_i;

  bridge_slave_port_ctrl #(
    .N_MASTER   (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW),
    .AUX_WIDTH  (XW),
    .MAX_OUTST  (MO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_req_i     (data_req_i),
    .data_add_i     (data_add_i),
    .data_wen_i     (data_wen_i),
    .data_wdata_i   (data_wdata_i),
    .data_be_i      (data_be_i),
    .data_aux_i     (data_aux_i),
    .data_ID_i      (data_ID_i),
    .data_gnt_o     (data_gnt_o),
    .data_r_valid_o (data_r_valid_o),
    .data_r_rdata_o (data_r_rdata_o),
    .data_r_opc_o   (data_r_opc_o),
    .data_r_aux_o   (data_r_aux_o),
    .slv_req_o      (slv_req_o),
    .slv_add_o      (slv_add_o),
    .slv_wen_o      (slv_wen_o),
    .slv_wdata_o    (slv_wdata_o),
    .slv_be_o       (slv_be_o),
    .slv_aux_o      (slv_aux_o),
    .slv_gnt_i      (slv_gnt_i),
    .slv_r_valid_i  (slv_r_valid_i),
    .slv_r_rdata_i  (slv_r_rdata_i),
    .slv_r_opc_i    (slv_r_opc_i),
    .slv_r_aux_i    (slv_r_aux_i)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [N-1:0] id;
    int unsigned  due;
  } pend_t;

  pend_t        pend[$];
  pend_t        pe;
  int unsigned  cyc = 0;
  int unsigned  tb_cnt = 0;
  int unsigned  cnt_before;
  int unsigned  rr_m = 0;
  int unsigned  lat = 1;
  int unsigned  release_n = 0;
  int unsigned  rv_m3 = 0;
  int unsigned  mw;
  bit           mhit;
  bit           exp_req;
  bit           resp_en = 1'b1;
  bit           inject = 1'b0;
  bit           drove = 1'b0;
  logic [N-1:0] exp_gnt;
  logic [N-1:0] exp_rid;
  logic [DW-1:0] exp_rd;
  logic          exp_opc;
  logic [XW-1:0] exp_aux;
  logic [DW-1:0] last_rd = '0;

  // IDs are a permutation of the master index so ID routing is distinguishable from index routing
  function automatic logic [N-1:0] id_of(input int unsigned m);
    logic [N-1:0] v;
    v = '0;
    v[(m * 5) % N] = 1'b1;
    return v;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Slave model and scoreboard: checks responses/arbitration, then schedules this cycle's events
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      tb_cnt        = 0;
      rr_m          = 0;
      drove         = 1'b0;
      last_rd       = '0;
      slv_r_valid_i = 1'b0;
    end else begin
      checks++;
      if (drove) begin
        if (data_r_valid_o !== exp_rid || data_r_rdata_o !== exp_rd ||
            data_r_opc_o !== exp_opc || data_r_aux_o !== exp_aux) begin
          errors++;
          $display("FAIL resp_data cyc %0d: got valid=%h rdata=%h opc=%b aux=%h, expected valid=%h rdata=%h opc=%b aux=%h",
                   cyc, data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_aux_o,
                   exp_rid, exp_rd, exp_opc, exp_aux);
        end
        if (data_r_valid_o === id_of(3)) rv_m3++;
        last_rd = exp_rd;
      end else if (data_r_valid_o !== '0) begin
        errors++;
        $display("FAIL resp_idle cyc %0d: got valid=%h, expected 0", cyc, data_r_valid_o);
      end

      mhit = 1'b0;
      mw   = 0;
      for (int unsigned k = 0; k < N; k++) begin
        if (!mhit && data_req_i[(rr_m + k) % N]) begin
          mhit = 1'b1;
          mw   = (rr_m + k) % N;
        end
      end
      exp_req = mhit && (tb_cnt < MO);
      checks++;
      if (slv_req_o !== exp_req) begin
        errors++;
        $display("FAIL slv_req cyc %0d: got %b, expected %b", cyc, slv_req_o, exp_req);
      end
      exp_gnt = '0;
      if (exp_req && slv_gnt_i) exp_gnt[mw] = 1'b1;
      checks++;
      if (data_gnt_o !== exp_gnt) begin
        errors++;
        $display("FAIL gnt cyc %0d: got %h, expected %h", cyc, data_gnt_o, exp_gnt);
      end
      if (exp_req) begin
        checks++;
        if ({slv_add_o, slv_wen_o, slv_wdata_o, slv_be_o, slv_aux_o} !==
            {data_add_i[mw], data_wen_i[mw], data_wdata_i[mw], data_be_i[mw], data_aux_i[mw]}) begin
          errors++;
          $display("FAIL payload cyc %0d: got %h, expected %h", cyc,
                   {slv_add_o, slv_wen_o, slv_wdata_o, slv_be_o, slv_aux_o},
                   {data_add_i[mw], data_wen_i[mw], data_wdata_i[mw], data_be_i[mw], data_aux_i[mw]});
        end
      end

      cnt_before = tb_cnt;
      if (exp_req && slv_gnt_i) begin
        pe.id  = data_ID_i[mw];
        pe.due = cyc + lat;
        pend.push_back(pe);
        rr_m   = (mw + 1) % N;
        tb_cnt++;
      end

      drove = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc && (resp_en || release_n > 0)) begin
        exp_rid       = pend[0].id;
        exp_rd        = $urandom;
        exp_opc       = 1'($urandom_range(0, 1));
        exp_aux       = 8'($urandom);
        slv_r_valid_i = 1'b1;
        slv_r_rdata_i = exp_rd;
        slv_r_opc_i   = exp_opc;
        slv_r_aux_i   = exp_aux;
        void'(pend.pop_front());
        tb_cnt--;
        drove = 1'b1;
        if (!resp_en) release_n--;
      end else if (inject && cnt_before == 0) begin
        slv_r_valid_i = 1'b1;
        slv_r_rdata_i = $urandom;
        slv_r_opc_i   = 1'b1;
        slv_r_aux_i   = 8'($urandom);
        inject        = 1'b0;
      end else begin
        slv_r_valid_i = 1'b0;
      end
      cyc++;
    end
  end

  task automatic drain();
    int unsigned t = 0;
    @(posedge clk); #1;
    data_req_i = '0;
    resp_en    = 1'b1;
    while ((tb_cnt != 0 || drove) && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    @(negedge clk); #1;
    checks++;
    if (tb_cnt != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding, expected 0", tb_cnt);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if (data_r_valid_o !== '0) begin errors++; $display("FAIL reset_rvalid: got %h, expected 0", data_r_valid_o); end
    checks++;
    if (data_r_rdata_o !== '0) begin errors++; $display("FAIL reset_rdata: got %h, expected 0", data_r_rdata_o); end
    checks++;
    if (data_r_opc_o !== 1'b0 || data_r_aux_o !== '0) begin
      errors++; $display("FAIL reset_opc_aux: got %b/%h, expected 0/0", data_r_opc_o, data_r_aux_o);
    end
    checks++;
    if (data_gnt_o !== '0 || slv_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_req_gnt: got %b/%h, expected 0/0", slv_req_o, data_gnt_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_master();
    int unsigned n = 0;
    int unsigned t = 0;
    lat = 2; resp_en = 1'b1; rv_m3 = 0;
    @(posedge clk); #1;
    slv_gnt_i = 1'b1;
    data_req_i = '0;
    data_req_i[3] = 1'b1;
    while (n < 3 && t < 20) begin
      @(negedge clk); #1;
      if (data_gnt_o[3]) n++;
      t++;
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL single_grants: got %0d, expected 3", n); end
    drain();
    checks++;
    if (rv_m3 != 3) begin errors++; $display("FAIL single_rvalid_count: got %0d, expected 3", rv_m3); end
  endtask

  task automatic test_round_robin();
    int unsigned got[6];
    int unsigned expv[6] = '{0, 5, 9, 0, 5, 9};
    int unsigned n = 0;
    int unsigned t = 0;
    pulse_reset();
    lat = 1; resp_en = 1'b1;
    @(posedge clk); #1;
    slv_gnt_i  = 1'b1;
    data_req_i = '0;
    data_req_i[0] = 1'b1;
    data_req_i[5] = 1'b1;
    data_req_i[9] = 1'b1;
    while (n < 6 && t < 30) begin
      @(negedge clk); #1;
      for (int unsigned b = 0; b < N; b++) begin
        if (data_gnt_o[b] && n < 6) begin
          got[n] = b;
          n++;
        end
      end
      t++;
    end
    for (int unsigned i = 0; i < 6; i++) begin
      checks++;
      if (i >= n || got[i] != expv[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got %0d, expected %0d", i, (i < n) ? got[i] : 99, expv[i]);
      end
    end
    drain();
  endtask

  task automatic test_full();
    int unsigned n = 0;
    lat = 1; resp_en = 1'b0; release_n = 0;
    @(posedge clk); #1;
    slv_gnt_i  = 1'b1;
    data_req_i = '0;
    data_req_i[2] = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      if (data_gnt_o != '0) n++;
    end
    checks++;
    if (n != MO) begin errors++; $display("FAIL full_grants: got %0d, expected %0d", n, MO); end
    checks++;
    if (slv_req_o !== 1'b0) begin errors++; $display("FAIL full_req_blocked: got %b, expected 0", slv_req_o); end
    @(posedge clk); #1;
    release_n = 1;
    n = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (data_gnt_o != '0) n++;
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL full_regrant: got %0d, expected 1", n); end
    checks++;
    if (slv_req_o !== 1'b0) begin errors++; $display("FAIL full_reblocked: got %b, expected 0", slv_req_o); end
    drain();
  endtask

  task automatic test_push_pop();
    int unsigned n = 0;
    int unsigned nfree;
    lat = 2; resp_en = 1'b1;
    @(posedge clk); #1;
    slv_gnt_i  = 1'b1;
    data_req_i = '0;
    data_req_i[1] = 1'b1;
    data_req_i[7] = 1'b1;
    repeat (8) begin
      @(negedge clk); #1;
      if (data_gnt_o != '0) n++;
    end
    checks++;
    if (n != 8) begin errors++; $display("FAIL pushpop_grants: got %0d, expected 8", n); end
    @(posedge clk); #1;
    data_req_i = '0;
    resp_en    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    nfree = MO - tb_cnt;
    @(posedge clk); #1;
    data_req_i[1] = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (data_gnt_o != '0) n++;
    end
    checks++;
    if (n != nfree) begin errors++; $display("FAIL pushpop_count: got %0d grants, expected %0d", n, nfree); end
    drain();
  endtask

  task automatic test_empty_response();
    int unsigned n = 0;
    @(posedge clk); #1;
    data_req_i = '0;
    inject = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (data_r_rdata_o !== last_rd) begin
      errors++; $display("FAIL empty_rdata_hold: got %h, expected %h", data_r_rdata_o, last_rd);
    end
    @(posedge clk); #1;
    resp_en = 1'b0;
    slv_gnt_i = 1'b1;
    data_req_i[4] = 1'b1;
    repeat (8) begin
      @(negedge clk); #1;
      if (data_gnt_o != '0) n++;
    end
    checks++;
    if (n != MO) begin errors++; $display("FAIL empty_count: got %0d grants, expected %0d", n, MO); end
    drain();
  endtask

  task automatic test_reset_midop();
    int unsigned n = 0;
    int unsigned t = 0;
    lat = 1; resp_en = 1'b0;
    @(posedge clk); #1;
    slv_gnt_i  = 1'b1;
    data_req_i = '0;
    data_req_i[6] = 1'b1;
    while (n < 3 && t < 20) begin
      @(negedge clk); #1;
      if (data_gnt_o != '0) n++;
      t++;
    end
    @(posedge clk); #1;
    slv_gnt_i  = 1'b0;
    data_req_i = '0;
    data_req_i[4]  = 1'b1;
    data_req_i[11] = 1'b1;
    data_req_i[13] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (data_r_valid_o !== '0 || data_r_rdata_o !== '0 || data_r_opc_o !== 1'b0 ||
        data_r_aux_o !== '0 || data_gnt_o !== '0) begin
      errors++;
      $display("FAIL midop_reset_outputs: got valid=%h rdata=%h opc=%b aux=%h gnt=%h, expected all 0",
               data_r_valid_o, data_r_rdata_o, data_r_opc_o, data_r_aux_o, data_gnt_o);
    end
    @(posedge clk); #1;
    slv_gnt_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (data_gnt_o !== 16'h0010) begin
      errors++; $display("FAIL midop_first_grant: got %h, expected 0010", data_gnt_o);
    end
    repeat (3) @(negedge clk);
    drain();
  endtask

  initial begin
    rst           = 1'b1;
    data_req_i    = '0;
    slv_gnt_i     = 1'b0;
    slv_r_valid_i = 1'b0;
    slv_r_rdata_i = '0;
    slv_r_opc_i   = 1'b0;
    slv_r_aux_i   = '0;
    for (int unsigned m = 0; m < N; m++) begin
      data_add_i[m]   = 32'h1000_0000 + m * 16;
      data_wen_i[m]   = m[0];
      data_wdata_i[m] = $urandom;
      data_be_i[m]    = BW'(m);
      data_aux_i[m]   = XW'(m * 3 + 1);
      data_ID_i[m]    = id_of(m);
    end
    test_reset();
    test_single_master();
    test_round_robin();
    test_full();
    test_push_pop();
    test_empty_response();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
